// File: rtl/usr_tx_ctrl.sv
// usr_tx_ctrl: sequences a universal shift register as a parallel-to-serial transmitter
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data word handshake;
// pause, abort controls; usr_en/usr_par drive the usr; bit_valid/bit_idx tag serial bits;
// frame, done, busy report progress.
module usr_tx_ctrl #(
  parameter int N = 8,
  parameter int GAP = 0,
  localparam int CW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          pause,
  input  logic          abort,
  output logic [1:0]    usr_en,
  output logic [N-1:0]  usr_par,
  output logic          bit_valid,
  output logic [CW-1:0] bit_idx,
  output logic          frame,
  output logic          done,
  output logic          busy
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [7:0] GLAST = 8'((GAP > 0) ? GAP - 1 : 0);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic [N-1:0] par_q, par_d;
  logic done_q, done_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      gcnt_q <= '0;
      par_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gcnt_q <= gcnt_d;
      par_q <= par_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gcnt_d = gcnt_q;
    par_d = par_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        par_d = in_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: if (!pause) begin
        if (cnt_q == LAST) begin
          done_d = 1'b1;
          cnt_d = '0;
          gcnt_d = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        gcnt_d = (gcnt_q == GLAST) ? gcnt_q : gcnt_q + 1'b1;
        state_d = (gcnt_q == GLAST) ? S_IDLE : S_GAP;
      end
    endcase
    // abort only matters once a word is in flight; an IDLE accept still wins
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d = '0;
      gcnt_d = '0;
      done_d = 1'b0;
    end
  end
  // pause must gate the enable in the same cycle so the usr and cnt stay in lockstep
  assign bit_valid = (state_q == S_SHIFT) && !pause;
  assign usr_en = (state_q == S_LOAD) ? 2'b11 : bit_valid ? 2'b01 : 2'b00;
  assign in_ready = (state_q == S_IDLE);
  assign busy = (state_q != S_IDLE);
  assign frame = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bit_idx = cnt_q;
  assign usr_par = par_q;
  assign done = done_q;
endmodule

// File: tb/tb_usr_tx_ctrl.sv
// tb_usr_tx_ctrl: directed checks of usr_tx_ctrl with GAP=0 and GAP=2 instances
module tb_usr_tx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, bit_valid, frame, done, busy;
  logic [1:0] usr_en;
  logic [7:0] usr_par;
  logic [2:0] bit_idx;
  logic iv2 = 1'b0, p2 = 1'b0, a2 = 1'b0;
  logic [7:0] d2 = '0;
  logic rdy2, bv2, frame2, done2, busy2;
  logic [1:0] en2;
  logic [7:0] par2;
  logic [2:0] idx2;
  logic [7:0] sr0 = '0, sr2 = '0;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  usr_tx_ctrl #(.N(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pause(pause), .abort(abort), .usr_en(usr_en), .usr_par(usr_par), .bit_valid(bit_valid),
    .bit_idx(bit_idx), .frame(frame), .done(done), .busy(busy));
  usr_tx_ctrl #(.N(8), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in_data(d2),
    .pause(p2), .abort(a2), .usr_en(en2), .usr_par(par2), .bit_valid(bv2),
    .bit_idx(idx2), .frame(frame2), .done(done2), .busy(busy2));
  // behavioural usr: load on 11, right shift on 01, serial_out = bit 0
  always @(posedge clk) begin
    sr0 <= (usr_en == 2'b11) ? usr_par : (usr_en == 2'b01) ? {1'b0, sr0[7:1]} : sr0;
    sr2 <= (en2 == 2'b11) ? par2 : (en2 == 2'b01) ? {1'b0, sr2[7:1]} : sr2;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".en"}, usr_en, 2'b00);
    chk({tag, ".rdy"}, in_ready, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".bv"}, bit_valid, 1'b0);
    chk({tag, ".idx"}, bit_idx, 3'd0);
    chk({tag, ".frame"}, frame, 1'b0);
  endtask
  task automatic xmit(input logic [7:0] d, input int pat, input int plen, input int aat, input int exp_done);
    int eb, pc;
    logic fin;
    eb = 0; pc = 0; fin = 1'b0;
    step; in_valid = 1'b1; in_data = d; #1;
    chk("acc.rdy", in_ready, 1'b1);
    step; in_valid = 1'b0; #1;
    chk("load.en", usr_en, 2'b11);
    chk("load.frame", frame, 1'b1);
    chk("load.par", usr_par, d);
    for (int cyc = 2; cyc <= 40 && !fin; cyc++) begin
      step;
      pause = (eb == pat && pc < plen);
      abort = (eb == aat);
      #1;
      if (eb == aat) begin
        chk("abt.en", usr_en, 2'b01);
        step; abort = 1'b0; #1;
        chk_idle("abt");
        chk("abt.done", done, 1'b0);
        step;
        chk("abt.done2", done, 1'b0);
        fin = 1'b1;
      end else if (pause) begin
        chk("pz.en", usr_en, 2'b00);
        chk("pz.bv", bit_valid, 1'b0);
        chk("pz.idx", bit_idx, eb);
        pc++;
      end else if (eb < 8) begin
        chk("sh.en", usr_en, 2'b01);
        chk("sh.bv", bit_valid, 1'b1);
        chk("sh.idx", bit_idx, eb);
        chk("sh.ser", sr0[0], d[eb]);
        chk("sh.done", done, 1'b0);
        eb++;
      end else begin
        chk("end.done", done, 1'b1);
        chk("end.cyc", cyc, exp_done);
        chk_idle("end");
        step;
        chk("end.pulse", done, 1'b0);
        fin = 1'b1;
      end
    end
    pause = 1'b0;
    abort = 1'b0;
    if (!fin) chk("xmit.timeout", 0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    // reset with in_valid asserted: nothing may be accepted
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) begin
      step;
      chk_idle("rst");
      chk("rst.done", done, 1'b0);
      chk("rst.par", usr_par, 8'h00);
    end
    rst = 1'b0; in_valid = 1'b0; #1;
    step;
    chk_idle("post_rst");
    chk("post_rst.par", usr_par, 8'h00);
    // plain word, done on cycle 10
    xmit(8'hA5, -1, 0, -1, 10);
    // pause 3 cycles at bit 3, done delayed by 3
    xmit(8'h3C, 3, 3, -1, 13);
    // abort at bit 4, then a full word from bit 0
    xmit(8'hB7, -1, 0, 4, 0);
    xmit(8'h69, -1, 0, -1, 10);
    // abort together with in_valid in IDLE: word accepted; abort in LOAD returns to IDLE
    step; in_valid = 1'b1; abort = 1'b1; in_data = 8'h11; #1;
    step; in_valid = 1'b0; #1;
    chk("idle_abt.en", usr_en, 2'b11);
    step; abort = 1'b0; #1;
    chk_idle("load_abt");
    // mid-word reset at bit 5
    step; in_valid = 1'b1; in_data = 8'hC3; #1;
    step; in_valid = 1'b0; #1;
    repeat (6) step;
    chk("mrst.idx", bit_idx, 3'd5);
    rst = 1'b1;
    step; rst = 1'b0; #1;
    chk_idle("mrst");
    chk("mrst.done", done, 1'b0);
    chk("mrst.par", usr_par, 8'h00);
    step;
    chk("mrst.done2", done, 1'b0);
    // back-to-back with GAP=2: second accept 12 cycles after the first
    step; iv2 = 1'b1; d2 = 8'hFF; #1;
    chk("b2b.rdy0", rdy2, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step; d2 = 8'h01; #1;
      if (k == 1) chk("b2b.ld1", en2, 2'b11);
      if (k == 9) chk("b2b.last1", en2, 2'b01);
      if (k == 10) chk("b2b.done", done2, 1'b1);
      if (k == 10 || k == 11) begin
        chk("b2b.gap_en", en2, 2'b00);
        chk("b2b.gap_busy", busy2, 1'b1);
        chk("b2b.gap_rdy", rdy2, 1'b0);
      end
      if (k == 11) chk("b2b.done_pulse", done2, 1'b0);
      if (k == 12) chk("b2b.rdy12", rdy2, 1'b1);
    end
    step; iv2 = 1'b0; #1;
    chk("b2b.ld2", en2, 2'b11);
    chk("b2b.par2", par2, 8'h01);
    for (int i = 0; i < 8; i++) begin
      step;
      chk("b2b.idx", idx2, i);
      chk("b2b.ser", sr2[0], (i == 0) ? 1'b1 : 1'b0);
    end
    step;
    chk("b2b.done2", done2, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
